// File: rtl/equation_checker.sv
// rtl/equation_checker.sv - operand entry, expression evaluation and retry/timeout scoring
// One instance per alarm equation slot; outcomes go to the alarm top FSM and VGA status.
module equation_checker #(
  parameter int WIDTH     = 8,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 1000000,
  parameter int TW        = 20
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Go,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] Target,
  input  logic [WIDTH-1:0] DataIn,
  output logic             Busy,
  output logic [1:0]       LoadIdx,
  output logic [WIDTH-1:0] Result,
  output logic             Correct,
  output logic             Wrong,
  output logic             TimedOut,
  output logic             DivZero,
  output logic             Done,
  output logic [1:0]       Tries
);

  localparam int CW = (MAX_TRIES < 4) ? 2 : $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LAST_TRY   = CW'(MAX_TRIES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_X, S_LOAD_Y, S_LOAD_Z, S_EXEC1, S_EXEC2, S_CMP, S_PASS, S_FAIL
  } state_t;

  state_t            state, state_nxt;
  logic              go_d;
  logic              go_rise;
  logic              in_load;
  logic              timeout_hit;
  logic              cmp_pass;
  logic              can_retry;
  logic [WIDTH-1:0]  x_q, y_q, z_q, target_q, inter_q;
  logic [WIDTH-1:0]  q_x, q_y;
  logic [1:0]        mode_q;
  logic [TW-1:0]     timer_q;
  logic [CW-1:0]     tries_q;

  assign go_rise     = Go & ~go_d;
  assign in_load     = (state == S_LOAD_X) || (state == S_LOAD_Y) || (state == S_LOAD_Z);
  assign timeout_hit = in_load && (timer_q == TIMER_LAST);
  assign cmp_pass    = (Result == target_q) && !DivZero;
  assign can_retry   = tries_q < LAST_TRY;
  // Divide-by-zero quotients are forced to 0 rather than left to the operator.
  assign q_x         = (z_q == '0) ? '0 : x_q / z_q;
  assign q_y         = (z_q == '0) ? '0 : y_q / z_q;
  assign Tries       = (tries_q >= CW'(3)) ? 2'd3 : tries_q[1:0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
      go_d  <= 1'b0;
    end else begin
      state <= state_nxt;
      go_d  <= Go;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_PASS, S_FAIL: if (Start) state_nxt = S_LOAD_X;
      S_LOAD_X: begin
        if (timeout_hit)  state_nxt = S_FAIL;
        else if (go_rise) state_nxt = S_LOAD_Y;
      end
      S_LOAD_Y: begin
        if (timeout_hit)  state_nxt = S_FAIL;
        else if (go_rise) state_nxt = S_LOAD_Z;
      end
      S_LOAD_Z: begin
        if (timeout_hit)  state_nxt = S_FAIL;
        else if (go_rise) state_nxt = S_EXEC1;
      end
      S_EXEC1: state_nxt = S_EXEC2;
      S_EXEC2: state_nxt = S_CMP;
      S_CMP: begin
        if (cmp_pass)       state_nxt = S_PASS;
        else if (can_retry) state_nxt = S_LOAD_X;
        else                state_nxt = S_FAIL;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (Abort) state_nxt = S_IDLE;
  end

  always_comb begin
    Busy    = 1'b0;
    LoadIdx = 2'd3;
    case (state)
      S_LOAD_X: begin Busy = 1'b1; LoadIdx = 2'd0; end
      S_LOAD_Y: begin Busy = 1'b1; LoadIdx = 2'd1; end
      S_LOAD_Z: begin Busy = 1'b1; LoadIdx = 2'd2; end
      S_EXEC1, S_EXEC2, S_CMP: Busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset || Abort) begin
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      target_q <= '0;
      inter_q  <= '0;
      mode_q   <= 2'd0;
      timer_q  <= '0;
      tries_q  <= '0;
      Result   <= '0;
      Correct  <= 1'b0;
      Wrong    <= 1'b0;
      TimedOut <= 1'b0;
      DivZero  <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      // Wrong is a pulse except in FAIL, where it is held until the next Start.
      if (state != S_FAIL) Wrong <= 1'b0;
      case (state)
        S_IDLE, S_PASS, S_FAIL: begin
          if (Start) begin
            target_q <= Target;
            mode_q   <= Mode;
            tries_q  <= '0;
            timer_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            Correct  <= 1'b0;
            Wrong    <= 1'b0;
            TimedOut <= 1'b0;
            DivZero  <= 1'b0;
          end
        end
        S_LOAD_X, S_LOAD_Y, S_LOAD_Z: begin
          timer_q <= timer_q + TW'(1);
          if (timeout_hit) begin
            TimedOut <= 1'b1;
            Wrong    <= 1'b1;
            Done     <= 1'b1;
          end else if (go_rise) begin
            case (state)
              S_LOAD_X: x_q <= DataIn;
              S_LOAD_Y: y_q <= DataIn;
              default:  z_q <= DataIn;
            endcase
          end
        end
        S_EXEC1: begin
          case (mode_q)
            2'd0:    inter_q <= q_x * q_x;
            2'd1:    inter_q <= x_q * y_q;
            2'd2:    inter_q <= x_q + y_q;
            default: inter_q <= x_q - y_q;
          endcase
        end
        S_EXEC2: begin
          case (mode_q)
            2'd0:    Result <= inter_q + q_y;
            2'd2:    Result <= inter_q * z_q;
            default: Result <= inter_q + z_q;
          endcase
          DivZero <= (mode_q == 2'd0) && (z_q == '0);
        end
        S_CMP: begin
          if (cmp_pass) begin
            Correct <= 1'b1;
            Done    <= 1'b1;
          end else begin
            tries_q <= tries_q + CW'(1);
            Wrong   <= 1'b1;
            if (can_retry) begin
              x_q     <= '0;
              y_q     <= '0;
              z_q     <= '0;
              timer_q <= '0;
            end else begin
              Done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_equation_checker.sv
// tb/tb_equation_checker.sv - scoreboard bench for equation_checker
// Stimulus pushes expected outcomes; a negedge monitor pops them on each Done/retry-Wrong event.
module tb_equation_checker;
  localparam int W  = 8;
  localparam int MT = 3;
  localparam int TO = 50;

  logic           Clock = 1'b0;
  logic           Reset = 1'b1;
  logic           Start = 1'b0;
  logic           Abort = 1'b0;
  logic           Go = 1'b0;
  logic [1:0]     Mode = 2'd0;
  logic [W-1:0]   Target = '0;
  logic [W-1:0]   DataIn = '0;
  logic           Busy, Correct, Wrong, TimedOut, DivZero, Done;
  logic [1:0]     LoadIdx, Tries;
  logic [W-1:0]   Result;

  equation_checker #(.WIDTH(W), .MAX_TRIES(MT), .TIMEOUT(TO), .TW(20)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort), .Go(Go),
    .Mode(Mode), .Target(Target), .DataIn(DataIn), .Busy(Busy), .LoadIdx(LoadIdx),
    .Result(Result), .Correct(Correct), .Wrong(Wrong), .TimedOut(TimedOut),
    .DivZero(DivZero), .Done(Done), .Tries(Tries)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int correct, wrong, timed_out, div_zero, done, result, tries, load_idx, due;
    bit chk_result, chk_tries;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, ev_cnt = 0, exp_cnt = 0;
  int   m_mode, m_target, m_tries;
  bit   m_over;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic int model_eval(input int mode, input int x, input int y, input int z);
    int q, r, v;
    q = (z == 0) ? 0 : x / z;
    r = (z == 0) ? 0 : y / z;
    case (mode)
      0:       v = q * q + r;
      1:       v = x * y + z;
      2:       v = (x + y) * z;
      default: v = x - y + z + 256;
    endcase
    return v % 256;
  endfunction

  initial forever begin
    @(negedge Clock);
    if (!Reset && (Done || (Wrong && Busy))) begin
      ev_cnt++;
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_outcome: Done=%0d Wrong=%0d Correct=%0d, expected no event (cycle %0d)",
                 Done, Wrong, Correct, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("correct", Correct, mon_e.correct);
        check("wrong", Wrong, mon_e.wrong);
        check("timed_out", TimedOut, mon_e.timed_out);
        check("div_zero", DivZero, mon_e.div_zero);
        check("done", Done, mon_e.done);
        check("load_idx", LoadIdx, mon_e.load_idx);
        check("outcome_cycle", cyc, mon_e.due);
        if (mon_e.chk_result) check("result", Result, mon_e.result);
        if (mon_e.chk_tries)  check("tries", Tries, mon_e.tries);
      end
    end
  end

  task automatic wait_outcome();
    int k = 0;
    while (ev_cnt < exp_cnt && k < 60) begin
      tick();
      k++;
    end
    check("outcome_seen", int'(ev_cnt >= exp_cnt), 1);
    if (ev_cnt < exp_cnt) begin
      sb_q.delete();
      exp_cnt = ev_cnt;
    end
  endtask

  task automatic start_problem(input int mode, input int target, output int entry);
    Mode   = mode[1:0];
    Target = target[W-1:0];
    Start  = 1'b1;
    tick();
    Start  = 1'b0;
    entry  = cyc;
    m_mode = mode; m_target = target; m_tries = 0; m_over = 0;
    check("start_load_idx", LoadIdx, 0);
  endtask

  task automatic press(input int v, input int gap);
    DataIn = v[W-1:0];
    Go = 1'b1;
    tick();
    Go = 1'b0;
    DataIn = W'($urandom);
    tick();
    repeat (gap) tick();
  endtask

  task automatic attempt(input int x, input int y, input int z, input bit go_in_exec,
                         input int gap, input bit skip_x);
    exp_t e;
    int   res, c;
    if (!skip_x) press(x, gap);
    press(y, gap);
    DataIn = z[W-1:0];
    Go = 1'b1;
    tick();
    c  = cyc;
    Go = 1'b0;
    res = model_eval(m_mode, x, y, z);
    e.result = res;
    e.div_zero = (m_mode == 0 && z == 0) ? 1 : 0;
    e.timed_out = 0;
    e.chk_result = 1;
    e.chk_tries = 1;
    e.due = c + 3;
    if (res == m_target && e.div_zero == 0) begin
      e.correct = 1; e.wrong = 0; e.done = 1; e.load_idx = 3;
      m_over = 1;
    end else begin
      m_tries++;
      e.correct = 0; e.wrong = 1;
      if (m_tries < MT) begin
        e.done = 0; e.load_idx = 0;
      end else begin
        e.done = 1; e.load_idx = 3;
        m_over = 1;
      end
    end
    e.tries = (m_tries > 3) ? 3 : m_tries;
    sb_q.push_back(e);
    exp_cnt++;
    tick();
    Go = go_in_exec;
    tick();
    Go = 1'b0;
    check("result_at_t3", Result, res);
    wait_outcome();
  endtask

  initial begin
    int   entry, tgt, cx, cy, cz, x, y, z, guard;
    exp_t e;

    repeat (3) tick();
    Reset = 1'b0;
    tick();
    check("rst_busy", Busy, 0);
    check("rst_load_idx", LoadIdx, 3);
    check("rst_result", Result, 0);
    check("rst_flags", {Correct, Wrong, TimedOut, DivZero, Done}, 0);
    check("rst_tries", Tries, 0);

    Go = 1'b1; DataIn = 8'd99;
    tick();
    Go = 1'b0;
    tick();
    check("idle_go_ignored", LoadIdx, 3);

    start_problem(0, 5, entry);
    attempt(4, 6, 2, 1'b1, 0, 1'b0);
    attempt(4, 2, 2, 1'b0, 0, 1'b0);

    start_problem(1, 154, entry);
    attempt(20, 20, 10, 1'b0, 1, 1'b0);
    start_problem(3, 255, entry);
    attempt(3, 5, 1, 1'b0, 0, 1'b0);

    start_problem(2, 0, entry);
    press(7, 0);
    press(8, 0);
    DataIn = 8'd3; Go = 1'b1;
    tick();
    Go = 1'b0;
    tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check("abort_busy", Busy, 0);
    check("abort_result", Result, 0);
    check("abort_load_idx", LoadIdx, 3);
    tick();
    check("abort_stays_idle", Busy, 0);

    start_problem(0, 0, entry);
    for (int i = 0; i < MT; i++) attempt(5, 5, 0, 1'b0, 0, 1'b0);
    tick(); tick();
    check("fail_wrong_held", Wrong, 1);
    check("fail_no_done", Done, 0);
    check("fail_tries", Tries, 3);

    start_problem(1, 37, entry);
    Go = 1'b1;
    for (int i = 0; i < 10; i++) begin
      DataIn = W'(11 + i);
      tick();
    end
    Go = 1'b0;
    tick();
    check("go_held_one_load", LoadIdx, 1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    check("start_in_load_y_ignored", LoadIdx, 1);
    attempt(11, 3, 4, 1'b0, 0, 1'b1);

    start_problem(2, 1, entry);
    e.correct = 0; e.wrong = 1; e.timed_out = 1; e.div_zero = 0; e.done = 1;
    e.result = 0; e.tries = 0; e.load_idx = 3; e.due = entry + TO;
    e.chk_result = 0; e.chk_tries = 0;
    sb_q.push_back(e);
    exp_cnt++;
    press(9, 0);
    while (cyc < entry + TO - 1) tick();
    DataIn = 8'd10; Go = 1'b1;
    tick();
    Go = 1'b0;
    wait_outcome();
    tick();
    check("timeout_held", TimedOut, 1);
    check("timeout_wrong_held", Wrong, 1);
    check("timeout_load_idx", LoadIdx, 3);

    for (int p = 0; p < 12; p++) begin
      m_mode = $urandom_range(0, 3);
      cx = $urandom_range(0, 255);
      cy = $urandom_range(0, 255);
      cz = (m_mode == 0) ? $urandom_range(0, 9) : $urandom_range(0, 255);
      tgt = model_eval(m_mode, cx, cy, cz);
      start_problem(m_mode, tgt, entry);
      guard = 0;
      while (!m_over && guard < MT + 1) begin
        if ($urandom_range(0, 2) == 0) begin
          x = cx; y = cy; z = cz;
        end else begin
          x = $urandom_range(0, 255);
          y = $urandom_range(0, 255);
          z = (m_mode == 0) ? $urandom_range(0, 9) : $urandom_range(0, 255);
        end
        attempt(x, y, z, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
        guard++;
      end
    end

    start_problem(1, 7, entry);
    attempt(2, 3, 1, 1'b0, 0, 1'b0);
    Reset = 1'b1; Start = 1'b1;
    tick();
    check("rst_start_busy", Busy, 0);
    check("rst_start_load_idx", LoadIdx, 3);
    check("rst_start_result", Result, 0);
    check("rst_start_flags", {Correct, Wrong, TimedOut, DivZero, Done}, 0);
    Reset = 1'b0; Start = 1'b0;
    tick();
    check("rst_start_idle", Busy, 0);

    repeat (3) tick();
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/equation_checker.md
Name: equation_checker

Overview:
- Parametrised successor of the alarm-clock equation checker.
- Latches a target value, then collects three operands (X, Y, Z) on user Go presses and evaluates one of four selectable expressions.
- Compares the result against the target, with retry counting and a per-attempt inactivity timeout.
- Sits under the alarm top-level FSM, one instance per equation slot. Feeds Correct/Wrong/Done to the top FSM and the VGA status logic.

Parameters:
- WIDTH, 8: data, target and result width. Arithmetic is modulo 2^WIDTH.
- MAX_TRIES, 3: attempts allowed before final failure; must be >= 1.
- TIMEOUT, 1000000: Clock cycles allowed per attempt for operand entry.
- TW, 20: timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- Clock  in  1  system clock, all logic posedge.
- Reset  in  1  synchronous, active-high; clock Clock.
- Start  in  1  level; sampled only in IDLE/PASS/FAIL.
- Abort  in  1  synchronous return to IDLE.
- Go  in  1  active-high user key; its rising edge loads one operand.
- Mode  in  2  expression select, latched at start.
- Target  in  WIDTH  expected answer, latched at start.
- DataIn  in  WIDTH  operand value.
- Busy  out  1  high from LOAD_X through CMP.
- LoadIdx  out  2  operand awaited: 0=X, 1=Y, 2=Z, 3=none.
- Result  out  WIDTH  last computed value.
- Correct  out  1  held high in PASS.
- Wrong  out  1  1-cycle pulse on retryable miss; held high in FAIL.
- TimedOut  out  1  held high in FAIL when failure was caused by timeout.
- DivZero  out  1  high when the last evaluation divided by zero.
- Done  out  1  1-cycle pulse on entering PASS or FAIL.
- Tries  out  2  failed attempts so far, saturating at 3.

Behaviour:
- Reset values:
  - All outputs 0, except LoadIdx=3.
  - State IDLE; X, Y, Z, target, mode, timer and Go_d all 0.
- Go edge: go_rise = Go & ~Go_d, with Go_d registered every cycle. A key held across state changes does not load again.
- States: IDLE, LOAD_X, LOAD_Y, LOAD_Z, EXEC1, EXEC2, CMP, PASS, FAIL.
- Entering a new problem:
  - IDLE, PASS or FAIL with Start=1: latch Target and Mode, Tries=0, clear Correct/Wrong/TimedOut/DivZero, go to LOAD_X.
  - Start is ignored in all other states.
- Operand loading:
  - LOAD_X / LOAD_Y / LOAD_Z: on go_rise, register DataIn into X / Y / Z respectively and advance.
  - Go is ignored in all other states.
- Timer:
  - Cleared on entry to LOAD_X, increments each cycle in any LOAD state.
  - When the timer reaches TIMEOUT-1, go to FAIL with TimedOut=1, Wrong=1, Done pulse. No retry.
  - If timeout and go_rise occur in the same cycle, timeout wins.
- Expressions (Mode):
  - 0: (X/Z)*(X/Z) + Y/Z
  - 1: X*Y + Z
  - 2: (X+Y)*Z
  - 3: X - Y + Z
  - Products are truncated to WIDTH bits and subtraction wraps. Division is unsigned integer division.
- Division by zero (modes 0 only): Z=0 makes the quotient 0 and sets DivZero=1. The attempt is scored wrong regardless of Target.
- Evaluation timing:
  - EXEC1 computes the intermediate term into an internal register.
  - EXEC2 writes Result.
  - CMP compares Result with the latched target.
  - If go_rise for Z is sampled in cycle t, Result updates at t+3 and the outcome is visible at t+4.
- Outcome from CMP:
  - Match and no DivZero: go to PASS, Correct=1, Done pulse.
  - Miss with Tries+1 < MAX_TRIES: Wrong 1-cycle pulse, Tries++, X/Y/Z cleared, target kept, back to LOAD_X.
  - Miss on the last try: Tries++, go to FAIL, Wrong held, Done pulse.
- PASS and FAIL hold until Start, Abort or Reset.
- Abort (any state): next state IDLE, all outputs return to reset values. Reset has priority over Abort. Abort has priority over every other event.
- Busy and LoadIdx are decoded from the registered state; no combinational path from inputs to outputs.

Test Plan:
- Mode 0: Target=5, X=4, Y=6, Z=2, each loaded by a single Go press -> Result=7 at t+3, Wrong pulse, Tries=1, LoadIdx=0. Retry with X=4, Y=2, Z=2 -> Result=5, Correct=1, Done pulse at t+4.
- Mode 1: X=20, Y=20, Z=10, Target=154 -> 410 mod 256 = 154, Correct=1 (checks truncation). Mode 3: X=3, Y=5, Z=1, Target=255 -> Correct=1 (checks wrap).
- Mode 0 with Z=0 and Target=0 -> Result=0, DivZero=1, counted as a miss. Run MAX_TRIES=3 misses -> third miss gives FAIL, Wrong held, Tries=3, a single Done pulse.
- TIMEOUT=50: Start, load X only -> FAIL 50 cycles after LOAD_X entry with TimedOut=1. A go_rise in the same cycle is ignored.
- Go held high for 10 cycles -> exactly one operand loads. A Go pulse while in IDLE or EXEC -> no load. Start during LOAD_Y -> no effect.
- Abort asserted in EXEC2 -> IDLE next cycle, Result=0, Busy=0. Reset asserted together with Start -> IDLE, outputs at reset values.
